// File: rtl/seg7_display_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg7_display_driver                                            |
// | Brief   : 4-digit multiplexed seven-segment driver with shadow register, |
// |           anti-ghost dead time, per-digit blank/blink and hex decode.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seg7_display_driver #(
    parameter int CLK_FREQ    = 100000000,
    parameter int STEP_HZ     = 4000,
    parameter int BLINK_HZ    = 2,
    parameter int DEAD_CYCLES = 16,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  blink,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_o,
    output logic [1:0]  digit
);

    localparam int c_step_div  = CLK_FREQ / STEP_HZ;
    localparam int c_blink_div = CLK_FREQ / (2 * BLINK_HZ);
    localparam int c_step_w    = $clog2(c_step_div) + 1;
    localparam int c_blink_w   = $clog2(c_blink_div) + 1;

    localparam logic [c_step_w-1:0]  c_step_last  = c_step_w'(c_step_div - 1);
    localparam logic [c_step_w-1:0]  c_dead       = c_step_w'(DEAD_CYCLES);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(c_blink_div - 1);
    localparam logic                 c_inv        = (ACTIVE_LOW != 0);

    logic [c_step_w-1:0]  r_step_cnt;
    logic [1:0]           r_digit;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_phase;

    logic [15:0] r_value;
    logic [3:0]  r_blank;
    logic [3:0]  r_blink;
    logic [3:0]  r_dp;

    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp_o;

    logic [3:0]  w_nibble;
    logic [6:0]  w_hex;
    logic        w_off;
    logic [3:0]  w_an_hi;
    logic [6:0]  w_seg_hi;
    logic        w_dp_hi;

    // Scan and blink timebases run independently of each other and of load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_cnt    <= '0;
            r_digit       <= 2'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (r_step_cnt == c_step_last) begin
                r_step_cnt <= '0;
                r_digit    <= r_digit + 2'd1;
            end else begin
                r_step_cnt <= r_step_cnt + 1'b1;
            end
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= 16'h0000;
            r_blank <= 4'hF;
            r_blink <= 4'h0;
            r_dp    <= 4'h0;
        end else if (load) begin
            r_value <= value;
            r_blank <= blank;
            r_blink <= blink;
            r_dp    <= dp;
        end
    end

    assign w_nibble = r_value[{r_digit, 2'b00} +: 4];

    always_comb begin
        w_hex = 7'b0000000;
        case (w_nibble)
            4'h0: w_hex = 7'b0111111;
            4'h1: w_hex = 7'b0000110;
            4'h2: w_hex = 7'b1011011;
            4'h3: w_hex = 7'b1001111;
            4'h4: w_hex = 7'b1100110;
            4'h5: w_hex = 7'b1101101;
            4'h6: w_hex = 7'b1111101;
            4'h7: w_hex = 7'b0000111;
            4'h8: w_hex = 7'b1111111;
            4'h9: w_hex = 7'b1101111;
            4'hA: w_hex = 7'b1110111;
            4'hB: w_hex = 7'b1111100;
            4'hC: w_hex = 7'b0111001;
            4'hD: w_hex = 7'b1011110;
            4'hE: w_hex = 7'b1111001;
            4'hF: w_hex = 7'b1110001;
            default: w_hex = 7'b0000000;
        endcase
    end

    // Dead time at the head of each slot lets the previous digit's anode drain.
    always_comb begin
        w_off    = (r_step_cnt < c_dead) | r_blank[r_digit] |
                   (r_blink[r_digit] & r_blink_phase);
        w_an_hi  = 4'b0000;
        w_seg_hi = 7'b0000000;
        w_dp_hi  = 1'b0;
        if (!w_off) begin
            w_an_hi  = 4'b0001 << r_digit;
            w_seg_hi = w_hex;
            w_dp_hi  = r_dp[r_digit];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an   <= {4{c_inv}};
            r_seg  <= {7{c_inv}};
            r_dp_o <= c_inv;
        end else begin
            r_an   <= w_an_hi ^ {4{c_inv}};
            r_seg  <= w_seg_hi ^ {7{c_inv}};
            r_dp_o <= w_dp_hi ^ c_inv;
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign dp_o  = r_dp_o;
    assign digit = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_seg7_display_driver                                         |
// | Brief   : Directed self-checking bench for seg7_display_driver.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_seg7_display_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_o;
    logic [1:0]  digit;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // {an, seg, dp_o} with everything dark
    localparam logic [11:0] c_off = {4'b1111, 7'b1111111, 1'b1};

    seg7_display_driver #(
        .CLK_FREQ   (1000),
        .STEP_HZ    (100),
        .BLINK_HZ   (25),
        .DEAD_CYCLES(2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .value(value),
        .blank(blank),
        .blink(blink),
        .dp   (dp),
        .an   (an),
        .seg  (seg),
        .dp_o (dp_o),
        .digit(digit)
    );

    always #5 clk = ~clk;

    // Edges counted since reset release: after edge k, cyc == k.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        load  = 1'b0;
        value = 16'h0000;
        blank = 4'h0;
        blink = 4'h0;
        dp    = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Advance to #1 after edge n, checking the one-hot anode invariant each cycle.
    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
            n_checks++;
            if ($countones(~an) > 1) begin
                n_fail++;
                $display("FAIL onehot_an: cyc=%0d an=%b required at most one low bit", cyc, an);
            end
        end
        if (cyc != n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_timeout: cyc=%0d required %0d", cyc, n);
        end
    endtask

    // Call at #1 after edge L-1; load is sampled at edge L.
    task automatic do_load(input logic [15:0] v, input logic [3:0] bk,
                           input logic [3:0] bl, input logic [3:0] d);
        value = v;
        blank = bk;
        blink = bl;
        dp    = d;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if ({an, seg, dp_o} !== c_off) begin
            n_fail++;
            $display("FAIL reset_out: got %b required %b", {an, seg, dp_o}, c_off);
        end
        n_checks++;
        if (digit !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_digit: got %0d required 0", digit);
        end
        wait_cyc(9);
        n_checks++;
        if (digit !== 2'd0) begin
            n_fail++;
            $display("FAIL scan_d0: got %0d required 0", digit);
        end
        wait_cyc(10);
        n_checks++;
        if (digit !== 2'd1) begin
            n_fail++;
            $display("FAIL scan_d1: got %0d required 1", digit);
        end
        wait_cyc(25);
        n_checks++;
        if (digit !== 2'd2) begin
            n_fail++;
            $display("FAIL scan_d2: got %0d required 2", digit);
        end
        wait_cyc(33);
        n_checks++;
        if (digit !== 2'd3 || {an, seg, dp_o} !== c_off) begin
            n_fail++;
            $display("FAIL blank_d3: digit=%0d out=%b required 3 %b", digit, {an, seg, dp_o}, c_off);
        end
        wait_cyc(40);
        n_checks++;
        if (digit !== 2'd0 || {an, seg, dp_o} !== c_off) begin
            n_fail++;
            $display("FAIL wrap_d0: digit=%0d out=%b required 0 %b", digit, {an, seg, dp_o}, c_off);
        end
    endtask

    task automatic test_display();
        logic [11:0] exp_v [0:6];
        int          at    [0:6];
        exp_v[0] = c_off;                         at[0] = 2;
        exp_v[1] = {4'b1110, 7'b0011001, 1'b0};   at[1] = 3;
        exp_v[2] = {4'b1110, 7'b0011001, 1'b0};   at[2] = 10;
        exp_v[3] = c_off;                         at[3] = 11;
        exp_v[4] = {4'b1101, 7'b0110000, 1'b1};   at[4] = 13;
        exp_v[5] = {4'b1011, 7'b0100100, 1'b1};   at[5] = 23;
        exp_v[6] = {4'b0111, 7'b1111001, 1'b1};   at[6] = 33;
        reset_dut();
        wait_cyc(1);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0001);
        for (int i = 0; i < 7; i++) begin
            wait_cyc(at[i]);
            n_checks++;
            if ({an, seg, dp_o} !== exp_v[i]) begin
                n_fail++;
                $display("FAIL display_%0d: cyc=%0d got %b required %b", i, cyc, {an, seg, dp_o}, exp_v[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic [11:0] exp_v [0:4];
        int          at    [0:4];
        // Digit1 slots fall in blink phase 0, digit3 slots in phase 1.
        exp_v[0] = {4'b1101, 7'b0110000, 1'b1};   at[0] = 15;
        exp_v[1] = {4'b1011, 7'b0100100, 1'b1};   at[1] = 25;
        exp_v[2] = c_off;                         at[2] = 35;
        exp_v[3] = {4'b1110, 7'b0011001, 1'b1};   at[3] = 45;
        exp_v[4] = c_off;                         at[4] = 75;
        reset_dut();
        wait_cyc(1);
        do_load(16'h1234, 4'b0000, 4'b1010, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            wait_cyc(at[i]);
            n_checks++;
            if ({an, seg, dp_o} !== exp_v[i]) begin
                n_fail++;
                $display("FAIL blink_%0d: cyc=%0d got %b required %b", i, cyc, {an, seg, dp_o}, exp_v[i]);
            end
        end
    endtask

    task automatic test_midslot_load();
        logic [11:0] exp_v [0:3];
        int          at    [0:3];
        exp_v[0] = {4'b1011, 7'b0100100, 1'b1};   at[0] = 25;
        exp_v[1] = {4'b1011, 7'b0000011, 1'b1};   at[1] = 26;
        exp_v[2] = {4'b0111, 7'b0001000, 1'b1};   at[2] = 33;
        exp_v[3] = {4'b1110, 7'b0100001, 1'b1};   at[3] = 43;
        reset_dut();
        wait_cyc(1);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(24);
        do_load(16'hABCD, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            wait_cyc(at[i]);
            n_checks++;
            if ({an, seg, dp_o} !== exp_v[i]) begin
                n_fail++;
                $display("FAIL midload_%0d: cyc=%0d got %b required %b", i, cyc, {an, seg, dp_o}, exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_v [0:4];
        int          at    [0:4];
        exp_v[0] = {4'b0111, 7'b1111001, 1'b1};   at[0] = 40;
        exp_v[1] = c_off;                         at[1] = 41;
        exp_v[2] = {4'b1110, 7'b0000000, 1'b1};   at[2] = 43;
        exp_v[3] = {4'b1101, 7'b1111000, 1'b1};   at[3] = 53;
        exp_v[4] = c_off;                         at[4] = 73;
        reset_dut();
        wait_cyc(1);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(39);
        do_load(16'h5678, 4'b1000, 4'b0000, 4'b1000);
        n_checks++;
        if (digit !== 2'd0) begin
            n_fail++;
            $display("FAIL wrapload_digit: got %0d required 0", digit);
        end
        for (int i = 0; i < 5; i++) begin
            wait_cyc(at[i]);
            n_checks++;
            if ({an, seg, dp_o} !== exp_v[i]) begin
                n_fail++;
                $display("FAIL wrapload_%0d: cyc=%0d got %b required %b", i, cyc, {an, seg, dp_o}, exp_v[i]);
            end
        end
    endtask

    task automatic test_midscan_reset();
        reset_dut();
        wait_cyc(1);
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(15);
        n_checks++;
        if ({an, seg, dp_o} !== {4'b1101, 7'b0110000, 1'b1}) begin
            n_fail++;
            $display("FAIL prereset_lit: got %b required %b", {an, seg, dp_o}, {4'b1101, 7'b0110000, 1'b1});
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if ({an, seg, dp_o} !== c_off || digit !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset: out=%b digit=%0d required %b 0", {an, seg, dp_o}, digit, c_off);
        end
        wait_cyc(13);
        n_checks++;
        if ({an, seg, dp_o} !== c_off || digit !== 2'd1) begin
            n_fail++;
            $display("FAIL postreset_blank: out=%b digit=%0d required %b 1", {an, seg, dp_o}, digit, c_off);
        end
    endtask

    initial begin
        test_reset();
        test_display();
        test_blink();
        test_midslot_load();
        test_back_to_back();
        test_midscan_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
